// File: rtl/if_pc_sumador.sv
// Instruction-fetch PC incrementer: combinational PC+INCR plus a registered copy with valid/carry flags.
// Latency: o_PC_4 is combinational (0 cycles); o_PC_4_reg/o_valid/o_carry update 1 cycle after an enable edge.
// Backpressure: none; i_enable low stalls (holds) the registered outputs, i_flush clears them and overrides enable.
// Optional macro SUM_CARRY_EN: when defined, o_carry records the wrap-around of the captured sum; otherwise it is tied 0.
module if_pc_sumador #(
  parameter int unsigned NB_PC = 32,
  parameter int unsigned INCR  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NB_PC-1:0] i_PC,
  input  logic             i_enable,
  input  logic             i_flush,
  output logic [NB_PC-1:0] o_PC_4,
  output logic [NB_PC-1:0] o_PC_4_reg,
  output logic             o_valid,
  output logic             o_carry
);

  // Increment constant sized to the PC so the add never widens implicitly.
  localparam logic [NB_PC-1:0] INCR_V = NB_PC'(INCR);

  logic [NB_PC-1:0] pc_sum;

`ifdef SUM_CARRY_EN
  // One extra bit keeps the carry out of the MSB for the wrap flag.
  logic [NB_PC:0] pc_sum_ext;
  logic           carry_q;

  // Widened adder: low bits are the wrapped next PC, top bit is the wrap indication.
  always_comb begin
    pc_sum_ext = {1'b0, i_PC} + {1'b0, INCR_V};
    pc_sum     = pc_sum_ext[NB_PC-1:0];
  end

  // Wrap flag follows the same clear/capture/hold rules as the registered PC.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      carry_q <= 1'b0;
    end else if (i_flush) begin
      carry_q <= 1'b0;
    end else if (i_enable) begin
      carry_q <= pc_sum_ext[NB_PC];
    end
  end

  assign o_carry = carry_q;
`else
  // Plain modulo-2^NB_PC adder; the carry out is simply dropped.
  always_comb begin
    pc_sum = i_PC + INCR_V;
  end

  assign o_carry = 1'b0;
`endif

  // Sequential next PC for the next-PC mux, independent of clock and control.
  assign o_PC_4 = pc_sum;

  // IF/ID copy of PC+INCR: reset and flush clear it, enable captures, otherwise it holds.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_PC_4_reg <= '0;
      o_valid    <= 1'b0;
    end else if (i_flush) begin
      o_PC_4_reg <= '0;
      o_valid    <= 1'b0;
    end else if (i_enable) begin
      o_PC_4_reg <= pc_sum;
      o_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_pc_sumador.sv
// Testbench for if_pc_sumador: vector table, directed corner sequences, randomized run against a model.
// Latency: checks registered outputs 1 ns after each rising edge, combinational outputs after a short settle.
// Backpressure: not applicable; stalls exercised through i_enable=0.
module tb_if_pc_sumador;

  localparam int NB = 32;

  logic          clk;
  logic          rst;
  logic [NB-1:0] pc;
  logic          en;
  logic          fl;
  logic [NB-1:0] pc4;
  logic [NB-1:0] pc4_reg;
  logic          vld;
  logic          car;

  int tests;
  int fails;

  // Behavioural model state for the registered path.
  logic [NB-1:0] m_reg;
  logic          m_vld;
  logic          m_car;

  if_pc_sumador #(.NB_PC(NB), .INCR(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_PC      (pc),
    .i_enable  (en),
    .i_flush   (fl),
    .o_PC_4    (pc4),
    .o_PC_4_reg(pc4_reg),
    .o_valid   (vld),
    .o_carry   (car)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] pc_in;
    logic [NB-1:0] exp_sum;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic from the definition of PC+4.
  function automatic logic [NB-1:0] ref_sum(input logic [NB-1:0] p);
    logic [NB:0] s;
    s = {1'b0, p} + 33'd4;
    return s[NB-1:0];
  endfunction

  function automatic logic ref_wrap(input logic [NB-1:0] p);
    logic [NB:0] s;
    s = {1'b0, p} + 33'd4;
`ifdef SUM_CARRY_EN
    return s[NB];
`else
    return 1'b0 & s[NB];
`endif
  endfunction

  // Advance the model on the edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_reg = '0; m_vld = 1'b0; m_car = 1'b0;
    end else if (fl) begin
      m_reg = '0; m_vld = 1'b0; m_car = 1'b0;
    end else if (en) begin
      m_reg = ref_sum(pc); m_vld = 1'b1; m_car = ref_wrap(pc);
    end
  endtask

  task automatic step_and_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_reg"}, pc4_reg, m_reg);
    chk({tag, "_vld"}, NB'(vld), NB'(m_vld));
    chk({tag, "_car"}, NB'(car), NB'(m_car));
    chk({tag, "_sum"}, pc4, ref_sum(pc));
  endtask

  task automatic check_regs_zero(input string tag);
    chk({tag, "_reg"}, pc4_reg, '0);
    chk({tag, "_vld"}, NB'(vld), '0);
    chk({tag, "_car"}, NB'(car), '0);
  endtask

  initial begin
    tests = 0; fails = 0;
    m_reg = '0; m_vld = 1'b0; m_car = 1'b0;
    rst = 1'b1; pc = '0; en = 1'b0; fl = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0000_000A, 32'h0000_000E};
    vecs[2] = '{32'h0000_000F, 32'h0000_0013};
    vecs[3] = '{32'h0000_0008, 32'h0000_000C};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0003};

    // Reset state.
    #2;
    check_regs_zero("reset");

    // Combinational sweep while reset is held: o_PC_4 must track regardless.
    for (int i = 0; i < 6; i++) begin
      pc = vecs[i].pc_in;
      #20;
      chk($sformatf("comb_%0d", i), pc4, vecs[i].exp_sum);
    end

    // Release reset away from the clock edge; no enable yet -> registers stay 0.
    @(negedge clk);
    rst = 1'b0;
    pc = 32'h1234_5678;
    step_and_check("post_reset_idle");
    step_and_check("post_reset_idle2");

    // Wrap capture.
    pc = 32'hFFFF_FFFC; en = 1'b1;
    step_and_check("wrap");
    chk("wrap_sum", pc4, 32'h0);
    chk("wrap_reg_abs", pc4_reg, 32'h0);
    chk("wrap_vld_abs", NB'(vld), NB'(1));
`ifdef SUM_CARRY_EN
    chk("wrap_car_abs", NB'(car), NB'(1));
`else
    chk("wrap_car_abs", NB'(car), NB'(0));
`endif

    // Capture then stall three edges.
    pc = 32'h100; en = 1'b1;
    step_and_check("cap");
    chk("cap_abs", pc4_reg, 32'h104);
    pc = 32'h200; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_and_check($sformatf("stall_%0d", i));
      chk($sformatf("stall_abs_%0d", i), pc4_reg, 32'h104);
      chk($sformatf("stall_vld_%0d", i), NB'(vld), NB'(1));
      chk($sformatf("stall_comb_%0d", i), pc4, 32'h204);
    end

    // Flush beats simultaneous enable.
    pc = 32'h40; en = 1'b1; fl = 1'b1;
    step_and_check("flush");
    check_regs_zero("flush_abs");
    fl = 1'b0;

    // Recapture 0x104, then async reset mid-cycle.
    pc = 32'h100; en = 1'b1;
    step_and_check("recap");
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_regs_zero("async_rst");
    pc = 32'h0000_0ABC;
    #1;
    chk("async_rst_comb", pc4, 32'h0000_0AC0);
    m_reg = '0; m_vld = 1'b0; m_car = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
      en = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 9) == 0);
      step_and_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
